// File: rtl/fir_pkg.sv
// Shared constants, CTRL register layout and FSM states for the FIR coefficient controller.
package fir_pkg;
  localparam int N_TAPS     = 25;
  localparam int KERNEL_DIM = 5;
  localparam int CENTRE_TAP = (KERNEL_DIM * KERNEL_DIM) / 2;

  localparam logic [4:0] CTRL_IDX = 5'd25;
  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_LOAD_ID_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_e;

  // Identity kernel: unity gain on the centre tap, zero elsewhere.
  function automatic logic [31:0] identity_tap(input int k, input int frac);
    return (k == CENTRE_TAP) ? (32'd1 << frac) : 32'd0;
  endfunction
endpackage

// File: rtl/vs_edge_det.sv
// Vertical-sync leading-edge detector; edge_o is combinational on vs_i against a one-cycle delay.
module vs_edge_det #(
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_i,
  output logic edge_o
);
  logic vs_q;

  always_ff @(posedge clk) begin
    if (rst) vs_q <= ~VS_ACTIVE_HIGH;
    else     vs_q <= vs_i;
  end

  assign edge_o = (vs_i != vs_q) && (vs_i == VS_ACTIVE_HIGH);
endmodule

// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient banks for the 5x5 FIR; bus writes land in shadow,
// an armed commit copies shadow to active on the next vsync leading edge.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int COEFF_W        = 16,
  parameter int COEFF_FRAC     = 8,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 haddr,
  input  logic [31:0]                 hwdata,
  input  logic                        hwrite,
  input  logic                        hready,
  input  logic                        vs_i,
  output logic [N_TAPS*COEFF_W-1:0]   coeff_o,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic                        wr_err,
  output logic [15:0]                 frame_cnt
);
  state_e             state_q;
  logic [COEFF_W-1:0] shadow_q [N_TAPS];
  logic [COEFF_W-1:0] active_q [N_TAPS];
  logic               pending_q, done_q, err_q;
  logic [15:0]        frame_q;

  logic       vs_edge, wr_acc, is_coeff, bad_addr;
  logic       cmd_commit, cmd_load_id, cmd_abort;
  logic [4:0] widx;
  logic       unused_bits;

  vs_edge_det #(.VS_ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .vs_i   (vs_i),
    .edge_o (vs_edge)
  );

  assign widx        = haddr[6:2];
  assign wr_acc      = hwrite && hready;
  assign is_coeff    = wr_acc && (widx < 5'(N_TAPS));
  assign bad_addr    = wr_acc && (widx > CTRL_IDX);
  assign cmd_commit  = wr_acc && (widx == CTRL_IDX) && hwdata[CTRL_COMMIT_BIT];
  assign cmd_load_id = wr_acc && (widx == CTRL_IDX) && hwdata[CTRL_LOAD_ID_BIT];
  assign cmd_abort   = wr_acc && (widx == CTRL_IDX) && hwdata[CTRL_ABORT_BIT];
  assign unused_bits = ^{haddr[31:7], haddr[1:0], hwdata[31:COEFF_W]};

  function automatic logic [COEFF_W-1:0] id_tap(input int k);
    logic [31:0] t;
    t = identity_tap(k, COEFF_FRAC);
    return t[COEFF_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      frame_q   <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        shadow_q[k] <= id_tap(k);
        active_q[k] <= id_tap(k);
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= bad_addr;
      if (vs_edge) frame_q <= frame_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (is_coeff) shadow_q[widx] <= hwdata[COEFF_W-1:0];
          // LOAD_ID lands in the same clock the FSM arms, so a combined write commits identity
          if (cmd_load_id) begin
            for (int k = 0; k < N_TAPS; k++) shadow_q[k] <= id_tap(k);
          end
          if (cmd_commit) begin
            state_q   <= ARMED;
            pending_q <= 1'b1;
          end
        end
        ARMED: begin
          if (is_coeff || cmd_load_id) err_q <= 1'b1;
          if (cmd_abort) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
          end else if (vs_edge) begin
            active_q  <= shadow_q;
            done_q    <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= COMMIT;
          end
        end
        COMMIT: begin
          if (is_coeff || cmd_load_id) err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_taps
    assign coeff_o[g*COEFF_W +: COEFF_W] = active_q[g];
  end

  assign commit_pending = pending_q;
  assign commit_done    = done_q;
  assign wr_err         = err_q;
  assign frame_cnt      = frame_q;
endmodule
